// File: rtl/fp_pkg.sv
// Shared encodings for the floating-point square-root sequencer: rounding modes,
// flag bit positions, the canonical quiet NaN and the sequencer state type.
package fp_pkg;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  // Flag word layout is {inv, ov, un, nx}.
  localparam int FLAG_INV = 3;
  localparam int FLAG_OV  = 2;
  localparam int FLAG_UN  = 1;
  localparam int FLAG_NX  = 0;

  localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } seq_state_e;

  function automatic logic [3:0] flag_mask(input int idx);
    return 4'(1) << idx;
  endfunction

endpackage

// File: rtl/fp_seq_wdog.sv
// Wait-cycle counter: clears on clr_i, counts on en_i, saturates at MAX.
// Single-cycle update; expired_o is high while the count sits at MAX.
module fp_seq_wdog #(
  parameter int MAX = 64,
  parameter int CW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          en_i,
  output logic [CW-1:0] cnt_o,
  output logic          expired_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CW'(MAX))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign expired_o = (cnt_q == CW'(MAX));

endmodule

// File: rtl/fp_sqr_seq.sv
// Request/response sequencer around a multi-cycle sqrt core; minimum latency DONE_SKIP+2,
// one operation in flight, response held until consumed. FP_SQR_SEQ_TIMEOUT_EN enables the watchdog.
module fp_sqr_seq
  import fp_pkg::*;
#(
  parameter int W         = 32,
  parameter int DONE_SKIP = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [W-1:0] req_op,
  input  logic [2:0]   req_rm,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic [3:0]   rsp_flags,
  output logic         rsp_timeout,
  output logic [3:0]   flags_sticky,
  input  logic         flags_clr,
  output logic         busy,
  output logic [W-1:0] core_in1,
  output logic [2:0]   core_rm,
  output logic         core_act,
  input  logic [W-1:0] core_out,
  input  logic [3:0]   core_flags,
  input  logic         core_done
);

  localparam int CW = $clog2(TIMEOUT + 1);

  seq_state_e    state_q, state_d;
  logic [W-1:0]  core_in1_q;
  logic [2:0]    core_rm_q;
  logic [W-1:0]  rsp_data_q;
  logic [3:0]    rsp_flags_q;
  logic [3:0]    flags_sticky_q, flags_sticky_d;

  logic          capture;
  logic [W-1:0]  cap_data;
  logic [3:0]    cap_flags;
  logic          accept;

  logic [CW-1:0] wd_cnt;
  logic          wd_expired;

  fp_seq_wdog #(
    .MAX (TIMEOUT),
    .CW  (CW)
  ) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (state_q == ST_ISSUE),
    .en_i      ((state_q == ST_WAIT) && !wd_expired),
    .cnt_o     (wd_cnt),
    .expired_o (wd_expired)
  );

  assign accept = (state_q == ST_IDLE) && req_valid;

`ifdef FP_SQR_SEQ_TIMEOUT_EN
  logic cap_timeout;
  logic rsp_timeout_q;
`endif

  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    cap_data  = core_out;
    cap_flags = core_flags;
`ifdef FP_SQR_SEQ_TIMEOUT_EN
    cap_timeout = 1'b0;
`endif
    case (state_q)
      ST_IDLE:  if (req_valid) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        // Early done pulses belong to the previous operand and are ignored.
        if ((wd_cnt >= CW'(DONE_SKIP)) && core_done) begin
          capture = 1'b1;
          state_d = ST_RESP;
        end
`ifdef FP_SQR_SEQ_TIMEOUT_EN
        else if (wd_expired) begin
          capture     = 1'b1;
          cap_data    = W'(FP_QNAN);
          cap_flags   = flag_mask(FLAG_INV);
          cap_timeout = 1'b1;
          state_d     = ST_RESP;
        end
`endif
      end
      ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // A clear in the capture cycle must not drop the flags being captured.
  assign flags_sticky_d = (flags_clr ? 4'b0000 : flags_sticky_q) | (capture ? cap_flags : 4'b0000);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      core_in1_q     <= '0;
      core_rm_q      <= '0;
      rsp_data_q     <= '0;
      rsp_flags_q    <= '0;
      flags_sticky_q <= '0;
    end else begin
      state_q        <= state_d;
      flags_sticky_q <= flags_sticky_d;
      if (accept) begin
        core_in1_q <= req_op;
        core_rm_q  <= req_rm;
      end
      if (capture) begin
        rsp_data_q  <= cap_data;
        rsp_flags_q <= cap_flags;
      end
    end
  end

`ifdef FP_SQR_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_timeout_q <= 1'b0;
    end else if (capture) begin
      rsp_timeout_q <= cap_timeout;
    end
  end
  assign rsp_timeout = rsp_timeout_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  assign req_ready    = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign rsp_valid    = (state_q == ST_RESP);
  assign core_act     = (state_q == ST_ISSUE);
  assign core_in1     = core_in1_q;
  assign core_rm      = core_rm_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_flags    = rsp_flags_q;
  assign flags_sticky = flags_sticky_q;

endmodule

// File: tb/tb_fp_sqr_seq.sv
// Directed bench for fp_sqr_seq with a bench-driven stub sqrt core.
`timescale 1ns/1ps
module tb_fp_sqr_seq;
  import fp_pkg::*;

  localparam int W         = 32;
  localparam int DONE_SKIP = 2;
  localparam int TIMEOUT   = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [W-1:0] req_op = '0;
  logic [2:0]   req_rm = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [W-1:0] rsp_data;
  logic [3:0]   rsp_flags;
  logic         rsp_timeout;
  logic [3:0]   flags_sticky;
  logic         flags_clr = 1'b0;
  logic         busy;
  logic [W-1:0] core_in1;
  logic [2:0]   core_rm;
  logic         core_act;
  logic [W-1:0] core_out = '0;
  logic [3:0]   core_flags = '0;
  logic         core_done = 1'b0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_sqr_seq #(
    .W         (W),
    .DONE_SKIP (DONE_SKIP),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_rm       (req_rm),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_flags    (rsp_flags),
    .rsp_timeout  (rsp_timeout),
    .flags_sticky (flags_sticky),
    .flags_clr    (flags_clr),
    .busy         (busy),
    .core_in1     (core_in1),
    .core_rm      (core_rm),
    .core_act     (core_act),
    .core_out     (core_out),
    .core_flags   (core_flags),
    .core_done    (core_done)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issues one request and waits for rsp_valid; lat counts edges after the accept edge, -1 if none.
  task automatic issue_and_wait(input logic [31:0] op, input logic [2:0] rm, input int limit,
                                output int lat, output int acts, output int hold_err);
    req_op = op; req_rm = rm; req_valid = 1'b1;
    tick();
    req_valid = 1'b0; req_op = ~op; req_rm = ~rm;
    lat = 0; acts = 0; hold_err = 0;
    while (!rsp_valid && lat < limit) begin
      if (core_act) acts++;
      if (core_in1 !== op || core_rm !== rm) hold_err++;
      tick();
      lat++;
    end
    if (!rsp_valid) lat = -1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick(); tick();
    checks++;
    if ({rsp_valid, rsp_timeout, busy, core_act} !== 4'b0000) begin
      failures++; $display("FAIL reset_ctrl got %b want 0000", {rsp_valid, rsp_timeout, busy, core_act});
    end
    checks++;
    if (rsp_data !== 32'h0 || rsp_flags !== 4'h0 || flags_sticky !== 4'h0) begin
      failures++; $display("FAIL reset_data got %h/%b/%b want 0/0/0", rsp_data, rsp_flags, flags_sticky);
    end
    checks++;
    if (core_in1 !== 32'h0 || core_rm !== 3'h0) begin
      failures++; $display("FAIL reset_core got %h/%h want 0/0", core_in1, core_rm);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready got %b want 1", req_ready);
    end
  endtask

  task automatic test_sqrt4();
    int lat, acts, herr;
    core_out = 32'h4000_0000; core_flags = 4'b0000; core_done = 1'b1;
    issue_and_wait(32'h4080_0000, RM_RNE, 50, lat, acts, herr);
    checks++;
    if (lat !== DONE_SKIP + 2) begin
      failures++; $display("FAIL sqrt4_latency got %0d want %0d", lat, DONE_SKIP + 2);
    end
    checks++;
    if (acts !== 1) begin
      failures++; $display("FAIL sqrt4_act_pulses got %0d want 1", acts);
    end
    checks++;
    if (herr !== 0) begin
      failures++; $display("FAIL sqrt4_operand_hold got %0d changes want 0", herr);
    end
    checks++;
    if (rsp_data !== 32'h4000_0000 || rsp_flags !== 4'b0000 || rsp_timeout !== 1'b0) begin
      failures++; $display("FAIL sqrt4_result got %h/%b/%b want 40000000/0000/0", rsp_data, rsp_flags, rsp_timeout);
    end
    checks++;
    if (flags_sticky !== 4'b0000) begin
      failures++; $display("FAIL sqrt4_sticky got %b want 0000", flags_sticky);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      failures++; $display("FAIL sqrt4_drain got valid=%b ready=%b want 0/1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_sqrt2();
    int lat, acts, herr;
    core_out = 32'h3FB5_04F3; core_flags = 4'b0001; core_done = 1'b1;
    issue_and_wait(32'h4000_0000, RM_RNE, 50, lat, acts, herr);
    checks++;
    if (lat !== DONE_SKIP + 2 || rsp_data !== 32'h3FB5_04F3 || rsp_flags !== 4'b0001) begin
      failures++; $display("FAIL sqrt2_result got lat=%0d %h/%b want 4 3fb504f3/0001", lat, rsp_data, rsp_flags);
    end
    checks++;
    if (flags_sticky !== 4'b0001) begin
      failures++; $display("FAIL sqrt2_sticky got %b want 0001", flags_sticky);
    end
    tick();
  endtask

  task automatic test_neg_clear();
    core_out = 32'h7FC0_0000; core_flags = 4'b1000; core_done = 1'b1;
    req_op = 32'hBF80_0000; req_rm = RM_RTZ; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick(); tick(); tick();
    flags_clr = 1'b1;
    tick();
    flags_clr = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h7FC0_0000 || rsp_flags !== 4'b1000) begin
      failures++; $display("FAIL neg_result got %b %h/%b want 1 7fc00000/1000", rsp_valid, rsp_data, rsp_flags);
    end
    checks++;
    if (flags_sticky !== 4'b1000) begin
      failures++; $display("FAIL neg_clear_capture got %b want 1000", flags_sticky);
    end
    tick();
    flags_clr = 1'b1;
    tick();
    flags_clr = 1'b0;
    checks++;
    if (flags_sticky !== 4'b0000) begin
      failures++; $display("FAIL sticky_clear got %b want 0000", flags_sticky);
    end
  endtask

  task automatic test_back_to_back();
    int lat, acts, herr;
    rsp_ready = 1'b0;
    core_out = 32'h4000_0000; core_flags = 4'b0000; core_done = 1'b1;
    issue_and_wait(32'h4080_0000, RM_RNE, 50, lat, acts, herr);
    core_out = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'h4000_0000 || req_ready !== 1'b0) begin
        failures++; $display("FAIL bp_hold cycle %0d got valid=%b data=%h ready=%b want 1/40000000/0",
                             i, rsp_valid, rsp_data, req_ready);
      end
    end
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_op = 32'h4110_0000; req_rm = RM_RNE;
    core_out = 32'h4040_0000;
    tick();
    checks++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++; $display("FAIL bp_handshake got busy=%b ready=%b valid=%b want 0/1/0", busy, req_ready, rsp_valid);
    end
    tick();
    req_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || core_in1 !== 32'h4110_0000) begin
      failures++; $display("FAIL bp_next_accept got busy=%b in1=%h want 1/41100000", busy, core_in1);
    end
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h4040_0000) begin
      failures++; $display("FAIL bp_second_result got %b/%h want 1/40400000", rsp_valid, rsp_data);
    end
    tick();
  endtask

  task automatic test_timeout();
    int lat, acts, herr;
    core_done = 1'b0; core_out = 32'h0BAD_0BAD; core_flags = 4'b0110;
    issue_and_wait(32'h4080_0000, RM_RNE, 60, lat, acts, herr);
`ifdef FP_SQR_SEQ_TIMEOUT_EN
    checks++;
    if (lat !== TIMEOUT + 2) begin
      failures++; $display("FAIL timeout_latency got %0d want %0d", lat, TIMEOUT + 2);
    end
    checks++;
    if (rsp_data !== 32'h7FC0_0000 || rsp_flags !== 4'b1000 || rsp_timeout !== 1'b1) begin
      failures++; $display("FAIL timeout_result got %h/%b/%b want 7fc00000/1000/1", rsp_data, rsp_flags, rsp_timeout);
    end
    checks++;
    if (flags_sticky !== 4'b1000) begin
      failures++; $display("FAIL timeout_sticky got %b want 1000", flags_sticky);
    end
    tick();
`else
    checks++;
    if (lat !== -1 || busy !== 1'b1 || rsp_timeout !== 1'b0) begin
      failures++; $display("FAIL no_watchdog got lat=%0d busy=%b to=%b want -1/1/0", lat, busy, rsp_timeout);
    end
`endif
  endtask

  task automatic test_reset_wait();
    int lat, acts, herr;
    core_done = 1'b0;
    if (req_ready) begin
      req_op = 32'h4080_0000; req_rm = RM_RUP; req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      tick(); tick(); tick();
    end
    checks++;
    if (busy !== 1'b1 || core_in1 !== 32'h4080_0000) begin
      failures++; $display("FAIL rstwait_pre got busy=%b in1=%h want 1/40800000", busy, core_in1);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({rsp_valid, rsp_timeout, busy, core_act, req_ready} !== 5'b00001) begin
      failures++; $display("FAIL rstwait_ctrl got %b want 00001", {rsp_valid, rsp_timeout, busy, core_act, req_ready});
    end
    checks++;
    if (rsp_data !== 32'h0 || rsp_flags !== 4'h0 || flags_sticky !== 4'h0 || core_in1 !== 32'h0 || core_rm !== 3'h0) begin
      failures++; $display("FAIL rstwait_data got %h/%b/%b/%h/%h want all 0", rsp_data, rsp_flags, flags_sticky, core_in1, core_rm);
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL rstwait_release got ready=%b busy=%b want 1/0", req_ready, busy);
    end
    core_out = 32'h4000_0000; core_flags = 4'b0000; core_done = 1'b1;
    issue_and_wait(32'h4080_0000, RM_RNE, 50, lat, acts, herr);
    checks++;
    if (lat !== DONE_SKIP + 2 || rsp_data !== 32'h4000_0000) begin
      failures++; $display("FAIL rstwait_recover got lat=%0d data=%h want 4/40000000", lat, rsp_data);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global time limit");
  end

  initial begin
    test_reset();
    test_sqrt4();
    test_sqrt2();
    test_neg_clear();
    test_back_to_back();
    test_timeout();
    test_reset_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
